// File: rtl/pvt_pkg.sv
// pvt_pkg: shared state encoding, read-address map and helpers for the PVT sequencer.
package pvt_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, GATE, CLKQ, SKEW, DONE} seq_state_t;
  localparam logic [1:0] RD_FCNT_LO = 2'd0;
  localparam logic [1:0] RD_FCNT_HI = 2'd1;
  localparam logic [1:0] RD_CLKQ    = 2'd2;
  localparam logic [1:0] RD_SKEW    = 2'd3;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/pvt_edge_counter.sv
// pvt_edge_counter: synchronizes the async ring-osc output and counts its rising edges, saturating.
module pvt_edge_counter #(
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_div,
  input  logic              ena,
  input  logic              clr,
  output logic [FCNT_W-1:0] cnt
);
  logic [2:0]        sync_q;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              rise;
  assign rise = sync_q[1] & ~sync_q[2];
  assign cnt  = cnt_q;
  always_comb cnt_d = clr ? '0 : (ena && rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], osc_div};
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/pvt_measure_sequencer.sv
// pvt_measure_sequencer: runs ring-osc frequency, clk-to-q and skew captures per sweep
// and publishes them atomically in a registered read bank.
module pvt_measure_sequencer
  import pvt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_CYCLES   = 1024,
  parameter int MEAS_WAIT     = 16,
  parameter int FCNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       osc_div,
  input  logic [7:0] measured_cnt,
  input  logic [6:0] skew_code,
  input  logic [1:0] rd_addr,
  input  logic       ack,
  output logic       ring_ena,
  output logic       meas_start,
  output logic       busy,
  output logic       result_valid,
  output logic [7:0] rd_data
);
  localparam int TW = $clog2(max3(SETTLE_CYCLES, GATE_CYCLES, MEAS_WAIT) + 1);
  seq_state_t        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              start_q, start_rise, load;
  logic [7:0]        clkq_q, clkq_d, bank_clkq_q, rd_q, rd_d;
  logic [6:0]        skew_q, skew_d, bank_skew_q;
  logic [FCNT_W-1:0] fcnt, bank_fcnt_q;
  logic [15:0]       fcnt16;
  logic              rv_q, rv_d;
  assign start_rise   = start & ~start_q;
  assign load         = state_q == DONE;
  assign ring_ena     = state_q == SETTLE || state_q == GATE;
  assign meas_start   = state_q == CLKQ && tmr_q == '0;
  assign busy         = state_q != IDLE;
  assign result_valid = rv_q;
  assign rd_data      = rd_q;
  assign fcnt16       = 16'(bank_fcnt_q);
  pvt_edge_counter #(.FCNT_W(FCNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .osc_div (osc_div),
    .ena     (state_q == GATE),
    .clr     (state_q == SETTLE),
    .cnt     (fcnt)
  );
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    clkq_d  = clkq_q;
    skew_d  = skew_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (start_rise) state_d = SETTLE;
      end
      SETTLE: if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
        state_d = GATE;
        tmr_d   = '0;
      end
      GATE: if (tmr_q == TW'(GATE_CYCLES - 1)) begin
        state_d = CLKQ;
        tmr_d   = '0;
      end
      CLKQ: if (tmr_q == TW'(MEAS_WAIT - 1)) begin
        clkq_d  = measured_cnt;
        state_d = SKEW;
        tmr_d   = '0;
      end
      SKEW: if (tmr_q == TW'(1)) begin
        skew_d  = skew_code;
        state_d = DONE;
        tmr_d   = '0;
      end
      DONE: begin
        state_d = continuous ? SETTLE : IDLE;
        tmr_d   = '0;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end
  // A DONE load outranks a coincident ack so a fresh result is never lost.
  always_comb rv_d = load ? 1'b1 : (ack || (state_q == IDLE && start_rise)) ? 1'b0 : rv_q;
  always_comb rd_d = rd_addr == RD_FCNT_LO ? fcnt16[7:0] :
                     rd_addr == RD_FCNT_HI ? fcnt16[15:8] :
                     rd_addr == RD_CLKQ    ? bank_clkq_q : {1'b0, bank_skew_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      start_q     <= 1'b1;
      clkq_q      <= '0;
      skew_q      <= '0;
      bank_fcnt_q <= '0;
      bank_clkq_q <= '0;
      bank_skew_q <= '0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      start_q     <= start;
      clkq_q      <= clkq_d;
      skew_q      <= skew_d;
      bank_fcnt_q <= load ? fcnt : bank_fcnt_q;
      bank_clkq_q <= load ? clkq_q : bank_clkq_q;
      bank_skew_q <= load ? skew_q : bank_skew_q;
      rv_q        <= rv_d;
      rd_q        <= rd_d;
    end
  end
endmodule

// File: tb/tb_pvt_measure_sequencer.sv
// tb_pvt_measure_sequencer: scoreboard bench for the PVT sweep sequencer.
module tb_pvt_measure_sequencer;
  localparam int SWEEP = 64 + 1024 + 16 + 2 + 1;
  typedef struct {int fcnt; int tol; logic [7:0] clkq; logic [6:0] skew;} exp_t;
  logic clk = 0, rst = 1, start = 0, continuous = 0, osc = 0, osc_fast = 0, ack = 0;
  logic [7:0] measured_cnt = 0;
  logic [6:0] skew_code = 0;
  logic [1:0] rd_addr = 0;
  logic ring_ena, meas_start, busy, result_valid;
  logic [7:0] rd_data;
  logic ring_ena8, meas_start8, busy8, result_valid8;
  logic [7:0] rd_data8;
  int checks = 0, errors = 0, ms_cnt = 0;
  exp_t sb[$];
  int sb8[$];

  pvt_measure_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .osc_div(osc),
    .measured_cnt(measured_cnt), .skew_code(skew_code), .rd_addr(rd_addr), .ack(ack),
    .ring_ena(ring_ena), .meas_start(meas_start), .busy(busy),
    .result_valid(result_valid), .rd_data(rd_data)
  );
  pvt_measure_sequencer #(.FCNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .osc_div(osc_fast),
    .measured_cnt(measured_cnt), .skew_code(skew_code), .rd_addr(rd_addr), .ack(ack),
    .ring_ena(ring_ena8), .meas_start(meas_start8), .busy(busy8),
    .result_valid(result_valid8), .rd_data(rd_data8)
  );

  always #5 clk = ~clk;
  initial begin #3; forever #40 osc = ~osc; end
  initial begin #7; forever #10 osc_fast = ~osc_fast; end
  always @(negedge clk) if (meas_start) ms_cnt++;
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d, output logic [7:0] d8);
    rd_addr = a;
    cyc(1);
    d  = rd_data;
    d8 = rd_data8;
  endtask

  task automatic launch(input string name);
    start = 0;
    cyc(1);
    start = 1;
    cyc(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, busy); end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 2 * SWEEP; i++) begin
      cyc(1);
      if (result_valid === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: result_valid got 0 want 1", name); end
  endtask

  task automatic drain_sweep(input string name);
    exp_t e;
    logic [7:0] lo, hi, cq, sk, x;
    int f;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s_sb_empty: got 0 entries want 1", name);
    end else begin
      e = sb.pop_front();
      rd(2'd0, lo, x); rd(2'd1, hi, x); rd(2'd2, cq, x); rd(2'd3, sk, x);
      f = {hi, lo};
      if (f < e.fcnt - e.tol || f > e.fcnt + e.tol) begin
        errors++; $display("FAIL %s_fcnt: got %0d want %0d+-%0d", name, f, e.fcnt, e.tol);
      end
      checks++;
      if (cq !== e.clkq) begin errors++; $display("FAIL %s_clkq: got %h want %h", name, cq, e.clkq); end
      checks++;
      if (sk !== {1'b0, e.skew}) begin errors++; $display("FAIL %s_skew: got %h want %h", name, sk, {1'b0, e.skew}); end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 1;
    cyc(3);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++;
      if ({busy, ring_ena, meas_start, result_valid, rd_data} !== 12'h0)
        begin errors++; $display("FAIL reset_outputs: got %b%b%b%b_%h want 0000_00", busy, ring_ena, meas_start, result_valid, rd_data); end
    end
  endtask

  task automatic test_frequency();
    int m0;
    measured_cnt = 8'h5A; skew_code = 7'h23; continuous = 0;
    sb.push_back('{128, 1, 8'h5A, 7'h23});
    sb8.push_back(255);
    m0 = ms_cnt;
    launch("freq");
    cyc(10);
    checks++;
    if (ring_ena !== 1'b1) begin errors++; $display("FAIL freq_ring_ena: got %b want 1", ring_ena); end
    wait_valid("freq");
    drain_sweep("freq");
    checks++;
    if (ms_cnt - m0 !== 1) begin errors++; $display("FAIL freq_meas_start_pulses: got %0d want 1", ms_cnt - m0); end
    cyc(20);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL freq_no_retrigger: busy got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    logic [7:0] lo, hi, x;
    int e;
    checks++;
    if (sb8.size() == 0) begin
      errors++; $display("FAIL sat_sb_empty: got 0 entries want 1");
    end else begin
      e = sb8.pop_front();
      rd(2'd0, x, lo); rd(2'd1, x, hi);
      if ({hi, lo} !== 16'(e)) begin errors++; $display("FAIL sat_fcnt: got %h want %h", {hi, lo}, 16'(e)); end
    end
    checks++;
    if (result_valid8 !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b want 1", result_valid8); end
  endtask

  task automatic test_ack();
    logic [7:0] d, x;
    ack = 1;
    cyc(1);
    ack = 0;
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b want 0", result_valid); end
    rd(2'd2, d, x);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL ack_bank_kept: got %h want 5a", d); end
  endtask

  task automatic test_back_to_back();
    int m0;
    logic [7:0] d, x;
    measured_cnt = 8'h11; skew_code = 7'h05; continuous = 1;
    sb.push_back('{128, 1, 8'h11, 7'h05});
    m0 = ms_cnt;
    launch("b2b");
    cyc(100);
    rd(2'd2, d, x);
    checks++;
    if (d !== 8'h5A) begin errors++; $display("FAIL b2b_prev_read: got %h want 5a", d); end
    wait_valid("b2b1");
    measured_cnt = 8'h33; skew_code = 7'h44;
    sb.push_back('{128, 1, 8'h33, 7'h44});
    drain_sweep("b2b1");
    continuous = 0;
    cyc(SWEEP - 1 - 4);
    ack = 1;
    cyc(1);
    ack = 0;
    checks++;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL b2b_ack_vs_done: result_valid got %b want 1", result_valid); end
    drain_sweep("b2b2");
    checks++;
    if (ms_cnt - m0 !== 2) begin errors++; $display("FAIL b2b_meas_start_pulses: got %0d want 2", ms_cnt - m0); end
    cyc(5);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int m0;
    measured_cnt = 8'h77; skew_code = 7'h1F; continuous = 0;
    launch("abort");
    cyc(64 + 100);
    checks++;
    if ({ring_ena, busy} !== 2'b11) begin errors++; $display("FAIL abort_in_gate: ring/busy got %b want 11", {ring_ena, busy}); end
    rst = 1;
    cyc(1);
    rst = 0;
    checks++;
    if ({ring_ena, meas_start, busy, result_valid, rd_data} !== 12'h0)
      begin errors++; $display("FAIL abort_cleared: got %b%b%b%b_%h want 0000_00", ring_ena, meas_start, busy, result_valid, rd_data); end
    sb.push_back('{128, 1, 8'h77, 7'h1F});
    m0 = ms_cnt;
    launch("abort_rerun");
    wait_valid("abort_rerun");
    drain_sweep("abort_rerun");
    checks++;
    if (ms_cnt - m0 !== 1) begin errors++; $display("FAIL abort_meas_start_pulses: got %0d want 1", ms_cnt - m0); end
  endtask

  initial begin
    test_reset();
    test_frequency();
    test_saturation();
    test_ack();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
